operand_arb: RTL and testbench
==============================

// Module: operand_arb
// PURPOSE
//  Shares the registered 8-bit operand pair input (a, b) of the datapath among N_REQ requesters.
//  Round-robin arbiter with optional burst lock.
//  Each requester offers one (a, b) beat per valid/ready handshake.
//  Winning beats pass through a single output register stage.
//  That register drives the datapath operand inputs, with a valid/ready handshake to the sink.
// PARAMETERS
//  N_REQ      4  number of requesters (>=2)
//  DATA_W     8  width of each operand
//  MAX_BURST  4  max consecutive beats one requester may hold the grant (>=1)
// PORTS
//  clk          in   1              clock
//  rst_n        in   1              reset, asynchronous, active-low
//  req_valid_i  in   N_REQ          requester i has a beat
//  req_last_i   in   N_REQ          beat is last of requester i's burst
//  req_a_i      in   N_REQ*DATA_W   operand a, requester i at [i*DATA_W +: DATA_W]
//  req_b_i      in   N_REQ*DATA_W   operand b, same packing
//  req_ready_o  out  N_REQ          beat of requester i accepted this cycle (one-hot or 0)
//  a_o          out  DATA_W         registered operand a to datapath
//  b_o          out  DATA_W         registered operand b to datapath
//  grant_id_o   out  $clog2(N_REQ)  source index of beat on a_o/b_o
//  valid_o      out  1              a_o/b_o/grant_id_o hold a beat
//  ready_i      in   1              sink takes beat when valid_o & ready_i
//  locked_o     out  1              FSM in LOCKED
// BEHAVIOUR
//  Reset values
//   - valid_o=0, a_o=0, b_o=0, grant_id_o=0, locked_o=0.
//   - Round-robin pointer ptr=0; state=IDLE.
//   - req_ready_o forced 0 while rst_n low.
//  Output register
//   - out_free = ~valid_o | ready_i.
//   - A beat accepted at cycle t appears on a_o/b_o/grant_id_o with valid_o=1 at t+1.
//   - Throughput: 1 beat/cycle while ready_i=1.
//   - valid_o & ~ready_i: a_o, b_o, grant_id_o held stable; no beat accepted.
//   - out_free & no beat accepted: valid_o <= 0; a_o/b_o/grant_id_o keep old values.
//  Handshake
//   - A beat transfers when req_valid_i[g] & req_ready_o[g].
//   - req_ready_o is combinational from req_valid_i, state, ptr, out_free.
//   - Requesters must not gate req_valid_i on req_ready_o.
//   - Requesters hold a/b/last stable while valid & ~ready.
//  FSM: IDLE, LOCKED
//   IDLE
//    - If out_free & |req_valid_i: g = first i with req_valid_i[i], scanning ptr, ptr+1, ... mod N_REQ.
//    - Set req_ready_o[g]=1; load output register.
//    - If req_last_i[g] or MAX_BURST==1: stay IDLE, ptr <= (g+1) mod N_REQ.
//    - Else: -> LOCKED, owner <= g, beat_cnt <= 1.
//   LOCKED
//    - Only owner is eligible: req_ready_o[owner] = out_free & req_valid_i[owner]; other bits 0.
//    - On beat: beat_cnt++.
//    - Release (-> IDLE, ptr <= owner+1) when req_last_i[owner] or beat_cnt+1 == MAX_BURST.
//    - out_free & ~req_valid_i[owner] (gap) ends the burst: -> IDLE, ptr <= owner+1, no beat that cycle.
//    - Other requesters' valids are ignored until release.
//  Width rules
//   - beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.
//   - ptr wraps N_REQ-1 -> 0.
//  Boundaries
//   - All requesters valid in IDLE: strict rotation; each gets a turn within N_REQ grants.
//   - Single requester valid: it is granted every eligible cycle; ptr still advances past it.
//   - Reset asserted mid-burst or with valid_o=1: lock dropped, pending output beat discarded, all reset values restored.
// TESTING
//  T1 reset
//   - Stimulus: rst_n low with all req_valid_i=1.
//   - Response: req_ready_o=0, valid_o=0, a_o=b_o=0.
//   - Release reset, ready_i=1 -> first grant to requester 0.
//  T2 round-robin
//   - Stimulus: all 4 valid, last=1, ready_i=1.
//   - Response: grant_id_o sequence 0,1,2,3,0 on consecutive cycles.
//   - Each a_o equals that requester's a.
//  T3 burst cap
//   - Stimulus: req1 valid, last=0 forever, req2 valid, MAX_BURST=4.
//   - Response: 4 beats from 1, then req2 granted, locked_o low after 4th beat.
//  T4 backpressure
//   - Stimulus: ready_i=0 for 3 cycles with valid_o=1, a_o=8'h5A.
//   - Response: a_o stays 8'h5A, all req_ready_o=0.
//   - On ready_i=1: next beat appears the following cycle.
//  T5 gap release
//   - Stimulus: req0 locked after beat 1, then drops valid one cycle while req3 valid.
//   - Response: next grant is req3; ptr=1.
//  T6 reset mid-burst
//   - Stimulus: rst_n pulsed low in LOCKED with valid_o=1.
//   - Response: valid_o=0 and locked_o=0 immediately.
//   - After release: grant restarts from requester 0.

Source files
------------

// File: rtl/operand_arb.sv
// operand_arb: round-robin arbiter with burst lock sharing one registered (a, b) operand pair among N_REQ requesters
module operand_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ-1:0]           req_last_i,
  input  logic [N_REQ*DATA_W-1:0]    req_a_i,
  input  logic [N_REQ*DATA_W-1:0]    req_b_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [DATA_W-1:0]          a_o,
  output logic [DATA_W-1:0]          b_o,
  output logic [$clog2(N_REQ)-1:0]   grant_id_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       locked_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, owner, owner_nxt, rr_g, idx, sel;
  logic [CW-1:0] beat_cnt, cnt_nxt;
  logic out_free, found, take;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (x == IW'(N_REQ - 1)) ? '0 : x + IW'(1);
  endfunction
  // first valid requester scanning upward from ptr, wrapping at N_REQ
  always_comb begin
    rr_g  = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        rr_g  = idx;
      end
    end
  end
  always_comb begin
    out_free    = ~valid_o | ready_i;
    sel         = (state == LOCKED) ? owner : rr_g;
    take        = out_free & ((state == LOCKED) ? req_valid_i[owner] : found);
    req_ready_o = (rst_n && take) ? N_REQ'(1) << sel : '0;
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    cnt_nxt     = beat_cnt;
    if (state == IDLE) begin
      if (take) begin
        if (req_last_i[sel] || MAX_BURST == 1) ptr_nxt = inc(sel);
        else begin
          state_nxt = LOCKED;
          owner_nxt = sel;
          cnt_nxt   = CW'(1);
        end
      end
    end else if (out_free) begin
      // a free output slot with no owner beat is a gap and ends the burst
      if (take) cnt_nxt = beat_cnt + CW'(1);
      if (!take || req_last_i[owner] || beat_cnt + CW'(1) == CW'(MAX_BURST)) begin
        state_nxt = IDLE;
        ptr_nxt   = inc(owner);
      end
    end
  end
  assign locked_o = (state == LOCKED);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      beat_cnt   <= '0;
      valid_o    <= 1'b0;
      a_o        <= '0;
      b_o        <= '0;
      grant_id_o <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= cnt_nxt;
      if (out_free) valid_o <= take;
      if (take) begin
        a_o        <= req_a_i[int'(sel)*DATA_W +: DATA_W];
        b_o        <= req_b_i[int'(sel)*DATA_W +: DATA_W];
        grant_id_o <= sel;
      end
    end
  end
endmodule

// File: tb/tb_operand_arb.sv
// tb_operand_arb: randomized and directed scoreboard bench for operand_arb
module tb_operand_arb;
  localparam int N = 4;
  localparam int MAXB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid_i = '0, req_last_i = '0, req_ready_o;
  logic [N*8-1:0] req_a_i = '0, req_b_i = '0;
  logic [7:0] a_o, b_o;
  logic [1:0] grant_id_o;
  logic valid_o, locked_o;
  logic ready_i = 1'b0;
  operand_arb #(.N_REQ(N), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_last_i(req_last_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_ready_o(req_ready_o),
    .a_o(a_o), .b_o(b_o), .grant_id_o(grant_id_o), .valid_o(valid_o),
    .ready_i(ready_i), .locked_o(locked_o)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  logic [17:0] sb[$];
  // reference view: owner of -1 means no burst lock held
  int m_ptr = 0, m_owner = -1, m_beats = 0;
  bit m_valid = 0;
  logic [N-1:0] va = '0, la = '0, pend = '0;
  logic [7:0] aa[N], ba[N];
  int fix_i = -1;
  logic [7:0] fix_v = '0;
  int obs;
  task automatic chk(input string n, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", n, act, exp);
  endtask
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy);
    int g;
    bit of;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pend[i]) begin
        va[i] = v[i];
        la[i] = l[i];
        aa[i] = (i == fix_i) ? fix_v : 8'($urandom);
        ba[i] = 8'($urandom);
      end
      req_a_i[i*8 +: 8] = aa[i];
      req_b_i[i*8 +: 8] = ba[i];
    end
    fix_i = -1;
    req_valid_i = va;
    req_last_i  = la;
    ready_i     = rdy;
    #1;
    of = !m_valid || rdy;
    g = -1;
    if (of) begin
      if (m_owner >= 0) begin
        if (va[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && va[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    chk("valid_o", int'(valid_o), int'(m_valid));
    chk("locked_o", int'(locked_o), int'(m_owner >= 0));
    obs = int'(req_ready_o);
    chk("req_ready", obs, g >= 0 ? (1 << g) : 0);
    if (of && m_owner >= 0 && g < 0) begin
      m_ptr = (m_owner + 1) % N;
      m_owner = -1;
    end
    if (g >= 0) begin
      sb.push_back({2'(g), aa[g], ba[g]});
      if (m_owner < 0) begin
        if (la[g] || MAXB == 1) m_ptr = (g + 1) % N;
        else begin
          m_owner = g;
          m_beats = 1;
        end
      end else begin
        m_beats++;
        if (la[g] || m_beats == MAXB) begin
          m_owner = -1;
          m_ptr = (g + 1) % N;
        end
      end
    end
    if (of) m_valid = (g >= 0);
    for (int i = 0; i < N; i++) pend[i] = va[i] && (g != i);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid_i = '1;
    #1;
    chk("rst_ready", int'(req_ready_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_a", int'(a_o), 0);
    chk("rst_b", int'(b_o), 0);
    chk("rst_gid", int'(grant_id_o), 0);
    repeat (2) @(negedge clk);
    req_valid_i = '0;
    rst_n = 1'b1;
    m_ptr = 0;
    m_owner = -1;
    m_valid = 0;
    pend = '0;
    va = '0;
    sb.delete();
  endtask
  // monitor: every beat the sink takes must match the oldest predicted beat
  always @(negedge clk) begin
    #2;
    if (rst_n && valid_o && ready_i) begin
      if (sb.size() == 0) chk("sb_size", sb.size(), 1);
      else chk("beat", int'({grant_id_o, a_o, b_o}), int'(sb.pop_front()));
    end
  end
  initial begin
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(4'hF, 4'hF, 1'b1);
      chk("t2_rr", obs, 1 << (i % N));
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0110, 4'b0000, 1'b1);
      chk("t3_burst", obs, 2);
    end
    @(posedge clk);
    #1;
    chk("t3_unlock", int'(locked_o), 0);
    cycle(4'b0110, 4'b0000, 1'b1);
    chk("t3_next", obs, 4);
    do_reset();
    fix_i = 0;
    fix_v = 8'h5A;
    cycle(4'b0001, 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0001, 4'b0001, 1'b0);
      chk("t4_ready", obs, 0);
      chk("t4_hold", int'(a_o), 8'h5A);
    end
    cycle(4'b0001, 4'b0001, 1'b1);
    chk("t4_resume", obs, 1);
    @(posedge clk);
    #1;
    chk("t4_valid", int'(valid_o), 1);
    do_reset();
    cycle(4'b1001, 4'b1000, 1'b1);
    chk("t5_lock", obs, 1);
    cycle(4'b1000, 4'b1000, 1'b1);
    chk("t5_gap", obs, 0);
    @(posedge clk);
    #1;
    chk("t5_ptr", int'(dut.ptr), 1);
    cycle(4'b1000, 4'b1000, 1'b1);
    chk("t5_next", obs, 8);
    do_reset();
    cycle(4'b0010, 4'b0000, 1'b1);
    cycle(4'b0010, 4'b0000, 1'b1);
    do_reset();
    cycle(4'hF, 4'hF, 1'b1);
    chk("t6_restart", obs, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      else cycle(4'($urandom), 4'($urandom), $urandom_range(3) != 0);
    end
    repeat (12) cycle(4'b0000, 4'b0000, 1'b1);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
